morse_rx_decoder: RTL and testbench

Receive-side counterpart of the board's Morse letter transmitter. Samples a single on/off key line, times marks and spaces in units of a one-unit tick enable, and classifies marks as dot or dash. It assembles up to 4 symbols and decodes letters A–H when an inter-letter gap is seen. Sits between the key/line input (GPIO or KEY) and the LEDR/HEX display logic.

---
 rtl/morse_rx_decoder.sv | 193 +++++++++++++++++++
 tb/tb_morse_rx_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx_decoder.sv
// Morse receive decoder: times marks and spaces against a unit tick and decodes letters A-H.
// Optional input deglitch filter enabled by defining MORSE_RX_DEGLITCH_EN.
module morse_rx_decoder #(
  parameter int CNT_W        = 4,
  parameter int DASH_MIN     = 2,
  parameter int MAX_MARK     = 6,
  parameter int LETTER_GAP   = 3,
  parameter int DEGLITCH_CYC = 3
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       tick,
  input  logic       line_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy,
  output logic [2:0] sym_len,
  output logic [3:0] sym_pattern
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_EMIT,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_MARK);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(LETTER_GAP);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync_q;
  logic             line_s;
  logic             line_f;
  logic             line_prev;
  logic             rise;
  logic             fall;
  logic             dec_hit;
  logic [2:0]       dec_letter;

  // Two-flop synchronizer on the asynchronous key line.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_q <= 1'b0;
      line_s <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q <= line_in;
      line_s <= sync_q;
    end
  end

`ifdef MORSE_RX_DEGLITCH_EN
  localparam int DG_W = (DEGLITCH_CYC > 1) ? $clog2(DEGLITCH_CYC) : 1;
  logic [DG_W-1:0] dg_cnt;

  // A new level is adopted only once it has persisted for DEGLITCH_CYC clocks.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dg_cnt <= '0;
      line_f <= 1'b0;
    end else if (line_s == line_f) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DG_W'(DEGLITCH_CYC - 1)) begin
      dg_cnt <= '0;
      line_f <= line_s;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end
`else
  assign line_f = line_s;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) line_prev <= 1'b0;
    else         line_prev <= line_f;
  end

  assign rise    = line_f & ~line_prev;
  assign fall    = ~line_f & line_prev;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign busy    = (state != S_IDLE);

  // Patterns are right-aligned with the oldest symbol in the highest used bit.
  function automatic logic [3:0] decode(input logic [2:0] len, input logic [3:0] pat);
    logic [3:0] res;
    res = 4'b0000;
    case ({len, pat})
      {3'd2, 4'b0001}: res = {1'b1, 3'd0};
      {3'd4, 4'b1000}: res = {1'b1, 3'd1};
      {3'd4, 4'b1010}: res = {1'b1, 3'd2};
      {3'd3, 4'b0100}: res = {1'b1, 3'd3};
      {3'd1, 4'b0000}: res = {1'b1, 3'd4};
      {3'd4, 4'b0010}: res = {1'b1, 3'd5};
      {3'd3, 4'b0110}: res = {1'b1, 3'd6};
      {3'd4, 4'b0000}: res = {1'b1, 3'd7};
      default:         res = 4'b0000;
    endcase
    return res;
  endfunction

  assign {dec_hit, dec_letter} = decode(sym_len, sym_pattern);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      sym_len      <= 3'd0;
      sym_pattern  <= 4'd0;
    end else begin
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt         <= '0;
          sym_len     <= 3'd0;
          sym_pattern <= 4'd0;
          if (rise) state <= S_MARK;
        end
        // An edge takes priority over a coincident tick, which is then dropped.
        S_MARK: begin
          if (fall) begin
            cnt <= '0;
            if (sym_len == 3'd4) begin
              state <= S_ERR;
            end else begin
              sym_pattern <= {sym_pattern[2:0], (cnt >= DASH_C)};
              sym_len     <= sym_len + 3'd1;
              state       <= S_SPACE;
            end
          end else if (tick) begin
            if (cnt_inc >= MAX_C) begin
              cnt   <= '0;
              state <= S_ERR;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_SPACE: begin
          if (rise) begin
            cnt   <= '0;
            state <= S_MARK;
          end else if (tick) begin
            if (cnt_inc >= GAP_C) begin
              cnt   <= '0;
              state <= S_EMIT;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_EMIT: begin
          if (dec_hit) begin
            letter       <= dec_letter;
            letter_valid <= 1'b1;
          end else begin
            letter_err <= 1'b1;
          end
          cnt         <= '0;
          sym_len     <= 3'd0;
          sym_pattern <= 4'd0;
          state       <= S_IDLE;
        end
        // Wait for a clean letter gap before accepting new input.
        S_ERR: begin
          if (line_f || fall) begin
            cnt <= '0;
          end else if (tick) begin
            if (cnt_inc >= GAP_C) begin
              cnt        <= '0;
              letter_err <= 1'b1;
              state      <= S_IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder: a scoreboard queue holds expected letter pulses.
module tb_morse_rx_decoder;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       tick;
  logic       line_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;
  logic [2:0] sym_len;
  logic [3:0] sym_pattern;

  typedef struct {
    logic       err;
    logic [2:0] ltr;
  } ev_t;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] last_letter;

  localparam int UNIT = 8;

  morse_rx_decoder dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .tick        (tick),
    .line_in     (line_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .busy        (busy),
    .sym_len     (sym_len),
    .sym_pattern (sym_pattern)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Morse unit at the given line level, with a tick in the middle.
  task automatic unit(input logic lvl);
    line_in = lvl;
    for (int c = 0; c < UNIT; c++) begin
      tick = (c == UNIT / 2);
      @(negedge Clock);
    end
    tick = 1'b0;
  endtask

  task automatic units(input logic lvl, input int n);
    for (int k = 0; k < n; k++) unit(lvl);
  endtask

  // Sends len symbols, oldest in bit len-1, then a letter gap plus slack.
  task automatic send_letter(input int len, input logic [3:0] pat);
    for (int i = len - 1; i >= 0; i--) begin
      units(1'b1, pat[i] ? 3 : 1);
      if (i > 0) unit(1'b0);
    end
    units(1'b0, 5);
  endtask

  task automatic expect_ev(input logic err, input logic [2:0] ltr);
    ev_t e;
    e.err = err;
    e.ltr = ltr;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check(tag, 8'(exp_q.size()), 8'd0);
  endtask

  always @(negedge Clock) begin
    ev_t e;
    if (Resetn === 1'b1 && (letter_valid === 1'b1 || letter_err === 1'b1)) begin
      check("pulse_excl", {7'd0, letter_valid & letter_err}, 8'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {6'd0, letter_err, letter_valid}, 8'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {7'd0, letter_err}, {7'd0, e.err});
        check("pulse_letter", {5'd0, letter}, {5'd0, e.ltr});
      end
    end
  end

  logic [2:0] lens [1:7];
  logic [3:0] pats [1:7];

  initial begin
    lens[1] = 3'd4; pats[1] = 4'b1000;
    lens[2] = 3'd4; pats[2] = 4'b1010;
    lens[3] = 3'd3; pats[3] = 4'b0100;
    lens[4] = 3'd1; pats[4] = 4'b0000;
    lens[5] = 3'd4; pats[5] = 4'b0010;
    lens[6] = 3'd3; pats[6] = 4'b0110;
    lens[7] = 3'd4; pats[7] = 4'b0000;

    Resetn  = 1'b0;
    tick    = 1'b0;
    line_in = 1'b0;
    last_letter = 3'd0;
    repeat (3) @(negedge Clock);
    check("rst_letter", {5'd0, letter}, 8'd0);
    check("rst_valid", {7'd0, letter_valid}, 8'd0);
    check("rst_err", {7'd0, letter_err}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_len", {5'd0, sym_len}, 8'd0);
    check("rst_pat", {4'd0, sym_pattern}, 8'd0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    // A: dot, dash, with intermediate symbol-register checks.
    expect_ev(1'b0, 3'd0);
    unit(1'b1);
    unit(1'b0);
    check("a_len1", {5'd0, sym_len}, 8'd1);
    check("a_pat1", {4'd0, sym_pattern}, 8'd0);
    check("a_busy", {7'd0, busy}, 8'd1);
    units(1'b1, 3);
    unit(1'b0);
    check("a_len2", {5'd0, sym_len}, 8'd2);
    check("a_pat2", {4'd0, sym_pattern}, 8'd1);
    units(1'b0, 4);
    drain("a_drain");
    last_letter = 3'd0;
    check("a_letter", {5'd0, letter}, 8'd0);
    check("a_len_clr", {5'd0, sym_len}, 8'd0);
    check("a_idle", {7'd0, busy}, 8'd0);

    for (int l = 1; l <= 7; l++) begin
      expect_ev(1'b0, 3'(l));
      send_letter(int'(lens[l]), pats[l]);
      drain("letter_drain");
      last_letter = 3'(l);
      check("letter_hold", {5'd0, letter}, {5'd0, last_letter});
    end

    // Five dots overflow the symbol register.
    expect_ev(1'b1, last_letter);
    for (int i = 0; i < 5; i++) begin
      unit(1'b1);
      unit(1'b0);
    end
    units(1'b0, 4);
    drain("five_drain");
    check("five_letter", {5'd0, letter}, {5'd0, last_letter});
    check("five_idle", {7'd0, busy}, 8'd0);

    // Over-long mark, held past the error threshold.
    expect_ev(1'b1, last_letter);
    units(1'b1, 8);
    check("long_busy", {7'd0, busy}, 8'd1);
    check("long_no_pulse", 8'(exp_q.size()), 8'd1);
    units(1'b0, 5);
    drain("long_drain");
    check("long_idle", {7'd0, busy}, 8'd0);

    // Two dashes: not in the table.
    expect_ev(1'b1, last_letter);
    send_letter(2, 4'b0011);
    drain("mm_drain");
    check("mm_letter", {5'd0, letter}, {5'd0, last_letter});

    // Asynchronous reset during B's second symbol.
    units(1'b1, 3);
    unit(1'b0);
    line_in = 1'b1;
    repeat (5) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("ar_letter", {5'd0, letter}, 8'd0);
    check("ar_busy", {7'd0, busy}, 8'd0);
    check("ar_len", {5'd0, sym_len}, 8'd0);
    check("ar_pat", {4'd0, sym_pattern}, 8'd0);
    check("ar_valid", {7'd0, letter_valid}, 8'd0);
    check("ar_err", {7'd0, letter_err}, 8'd0);
    line_in = 1'b0;
    @(negedge Clock);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    last_letter = 3'd0;
    repeat (2) @(negedge Clock);

    expect_ev(1'b0, 3'd4);
    send_letter(1, 4'b0000);
    drain("e_drain");
    check("e_letter", {5'd0, letter}, 8'd4);

    units(1'b0, 2);
    check("final_queue", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
